subb_byte_framer: RTL

- Downstream neighbour of the single-bit inversion stage; consumes its serial output bit stream.
- Hunts for a sync byte, then packs the following data bits MSB-first into bytes.
- Re-checks sync after every frame and delivers data bytes through a small FIFO with a valid/ready handshake.

---
 rtl/subb_byte_framer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/subb_byte_framer.sv
// ---------------------------------------------------------------------------
// subb_byte_framer
//
// Takes the serial bit stream from the single-bit inversion stage, hunts for a
// sync byte, then packs the data bits that follow MSB-first into bytes. The
// sync byte is checked again after every frame of FRAME_LEN data bytes. Data
// bytes leave through a small FIFO with a valid/ready handshake.
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   in_bit1      serial data bit from the upstream stage
//   in_valid     qualifies in_bit1; framer state holds while low
//   out_byte     FIFO head byte (8'h00 while empty)
//   out_valid    FIFO not empty
//   out_ready    consumer accepts out_byte when high with out_valid
//   locked       framer is in the LOCKED state
//   overflow     sticky: a data byte was dropped because the FIFO was full
//   sync_err_cnt saturating count of sync mismatches
// ---------------------------------------------------------------------------
module subb_byte_framer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FRAME_LEN  = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit1,
  input  logic             in_valid,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             locked,
  output logic             overflow,
  output logic [CNT_W-1:0] sync_err_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Elaboration-time parameter sanity checks.
  if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
    $error("FRAME_LEN must be in 1..255");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Framer
  // -------------------------------------------------------------------------
  state_t     state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;

  // Window including the bit being sampled this cycle; this is both the
  // sliding hunt window and, on the 8th bit in LOCKED, the completed byte.
  logic [7:0] window;
  logic       byte_done;
  logic       is_data;
  logic       sync_hit;
  logic       push;

  assign window    = {sr[6:0], in_bit1};
  assign sync_hit  = (window == SYNC_BYTE);
  assign byte_done = in_valid && (state == LOCKED) && (bit_cnt == 3'd7);
  // byte_cnt == FRAME_LEN marks the slot where the sync byte is expected.
  assign is_data   = (byte_cnt < 8'(FRAME_LEN));
  assign push      = byte_done && is_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HUNT;
      sr           <= 8'h00;
      bit_cnt      <= 3'd0;
      byte_cnt     <= 8'd0;
      sync_err_cnt <= '0;
    end else if (in_valid) begin
      sr <= window;
      case (state)
        HUNT: begin
          if (sync_hit) begin
            state    <= LOCKED;
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
          end
        end
        LOCKED: begin
          // 3-bit counter wraps 7 -> 0 on the bit that completes a byte.
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (is_data) begin
              byte_cnt <= byte_cnt + 8'd1;
            end else if (sync_hit) begin
              byte_cnt <= 8'd0;
            end else begin
              // Lost alignment: the next in_valid bit starts a fresh hunt.
              // The rejected byte was evaluated here, not in HUNT, so it
              // cannot match again on this same bit.
              state    <= HUNT;
              byte_cnt <= 8'd0;
              if (sync_err_cnt != {CNT_W{1'b1}})
                sync_err_cnt <= sync_err_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             do_push;

  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);

  // Storage is not reset; out_byte is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= window;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push)
        overflow <= 1'b1;
    end
  end

  assign out_byte = out_valid ? mem[rd_ptr] : 8'h00;

endmodule
